// File: rtl/int_issue_queue.sv
// int_issue_queue -- integer-unit reservation station.
//
// Holds up to DEPTH dispatched instructions in collapsing storage. Index 0 is
// always the oldest entry. The queue snoops the CDB to capture pending source
// operands. Each cycle it offers the oldest entry that has both operands
// valid to the integer execution unit.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   dispatch_en/_data     write request from dispatch (dropped when full or flushing)
//   flush                 mispredict flush; empties the queue at the next edge
//   cdb_valid/_tag/_data  common data bus broadcast
//   issue_ready           integer unit accepts this cycle
//   issue_valid/_data     oldest ready entry, or zero when none is ready
//   queue_full/_empty     occupancy flags
//   entry_count           number of occupied entries
//
// Optional build macro INT_IQ_CDB_BYPASS_EN: an entry whose missing operands
// match the current CDB broadcast is issuable in the same cycle, and the
// broadcast value is forwarded into issue_data.

package int_iq_pkg;
  localparam int IQ_TAG_W = 6;

  typedef struct packed {
    logic [IQ_TAG_W-1:0] rd_tag;
    logic [IQ_TAG_W-1:0] rs1_tag;
    logic [IQ_TAG_W-1:0] rs2_tag;
    logic                rs1_data_valid;
    logic                rs2_data_valid;
    logic [31:0]         rs1_data;
    logic [31:0]         rs2_data;
  } common_data_t;

  typedef struct packed {
    logic [6:0]   opcode;
    logic [2:0]   func3;
    logic [6:0]   func7;
    common_data_t common_data;
  } int_fifo_data;
endpackage

module int_issue_queue
  import int_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = IQ_TAG_W  // must match the tag width fixed by the entry struct
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dispatch_en,
  input  int_fifo_data                 dispatch_data,
  input  logic                         flush,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [31:0]                  cdb_data,
  input  logic                         issue_ready,
  output logic                         issue_valid,
  output int_fifo_data                 issue_data,
  output logic                         queue_full,
  output logic                         queue_empty,
  output logic [$clog2(DEPTH+1)-1:0]   entry_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Capture a broadcast into any still-pending source that is waiting on it.
  // Sources that are already valid are left untouched.
  function automatic int_fifo_data snoop(input int_fifo_data e, input logic v,
                                         input logic [TAG_W-1:0] t, input logic [31:0] d);
    int_fifo_data r;
    r = e;
    if (v && !r.common_data.rs1_data_valid && r.common_data.rs1_tag == t) begin
      r.common_data.rs1_data       = d;
      r.common_data.rs1_data_valid = 1'b1;
    end
    if (v && !r.common_data.rs2_data_valid && r.common_data.rs2_tag == t) begin
      r.common_data.rs2_data       = d;
      r.common_data.rs2_data_valid = 1'b1;
    end
    return r;
  endfunction

  int_fifo_data     ent_q [DEPTH];
  int_fifo_data     ent_d [DEPTH];
  int_fifo_data     view  [DEPTH];  // entry as seen by selection this cycle
  logic [CW-1:0]    count_q, count_d, wr_idx;
  logic [DEPTH-1:0] rdy;
  logic [IW-1:0]    sel;
  logic             fire, disp_acc;

  assign queue_full  = (count_q == CW'(DEPTH));
  assign queue_empty = (count_q == '0);
  assign entry_count = count_q;

  // Readiness. Storage collapses, so slot i is occupied exactly when i < count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef INT_IQ_CDB_BYPASS_EN
      view[i] = snoop(ent_q[i], cdb_valid, cdb_tag, cdb_data);
`else
      view[i] = ent_q[i];
`endif
      rdy[i] = (CW'(i) < count_q) && view[i].common_data.rs1_data_valid &&
               view[i].common_data.rs2_data_valid;
    end
  end

  // Lowest-index ready entry wins; scanning downward lets the oldest overwrite.
  always_comb begin
    issue_valid = 1'b0;
    issue_data  = '0;
    sel         = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy[i]) begin
        issue_valid = 1'b1;
        issue_data  = view[i];
        sel         = IW'(i);
      end
    end
  end

  assign fire     = issue_valid && issue_ready;
  assign disp_acc = dispatch_en && !queue_full && !flush;
  // A same-cycle issue frees one slot below the current tail.
  assign wr_idx   = count_q - CW'(fire);

  // Next state: collapse over the issued slot, snoop at the new position,
  // then place the (also snooped) dispatched entry at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = i;
      if (fire && i >= int'(sel) && i < DEPTH-1) src = i + 1;
      ent_d[i] = snoop(ent_q[src], cdb_valid, cdb_tag, cdb_data);
      if (disp_acc && CW'(i) == wr_idx)
        ent_d[i] = snoop(dispatch_data, cdb_valid, cdb_tag, cdb_data);
    end
    count_d = count_q + CW'(disp_acc) - CW'(fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      // Slots at or above count are don't-care, so flush only needs to clear count.
      count_q <= flush ? '0 : count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed, table-driven bench for int_issue_queue (default build, DEPTH=4).
// Each row drives inputs just after a rising edge and checks the outputs at the
// following falling edge, before the edge that consumes the row.
module tb_int_issue_queue;
  import int_iq_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dispatch_en;
  int_fifo_data dispatch_data;
  logic         flush;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic         issue_ready;
  logic         issue_valid;
  int_fifo_data issue_data;
  logic         queue_full;
  logic         queue_empty;
  logic [2:0]   entry_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .dispatch_en(dispatch_en), .dispatch_data(dispatch_data),
    .flush(flush), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_data(issue_data),
    .queue_full(queue_full), .queue_empty(queue_empty), .entry_count(entry_count)
  );

  typedef struct {
    logic        den;
    logic [6:0]  op;
    logic [5:0]  t1;
    logic        v1;
    logic [31:0] d1;
    logic [5:0]  t2;
    logic        v2;
    logic [31:0] d2;
    logic        cv;
    logic [5:0]  ct;
    logic [31:0] cd;
    logic        ir;
    logic        fl;
    logic        e_iv;
    logic [6:0]  e_op;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    int          e_cnt;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;

  task automatic add(input logic den, input logic [6:0] op, input logic [5:0] t1, input logic v1,
                     input logic [31:0] d1, input logic [5:0] t2, input logic v2, input logic [31:0] d2,
                     input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic ir,
                     input logic fl, input logic e_iv, input logic [6:0] e_op, input logic [31:0] e_d1,
                     input logic [31:0] e_d2, input int e_cnt);
    vecs[nv] = '{den, op, t1, v1, d1, t2, v2, d2, cv, ct, cd, ir, fl, e_iv, e_op, e_d1, e_d2, e_cnt};
    nv++;
  endtask

  // Shorthands: ready dispatch, idle row (optionally with CDB), expected-only args last.
  task automatic rdy_disp(input logic [6:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic ir, input logic fl, input logic e_iv, input logic [6:0] e_op,
                          input logic [31:0] e_d1, input logic [31:0] e_d2, input int e_cnt);
    add(1, op, 0, 1, d1, 0, 1, d2, 0, 0, 0, ir, fl, e_iv, e_op, e_d1, e_d2, e_cnt);
  endtask

  task automatic idle(input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic ir,
                      input logic e_iv, input logic [6:0] e_op, input logic [31:0] e_d1,
                      input logic [31:0] e_d2, input int e_cnt);
    add(0, 0, 0, 0, 0, 0, 0, 0, cv, ct, cd, ir, 0, e_iv, e_op, e_d1, e_d2, e_cnt);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    dispatch_en = 0; dispatch_data = '0; flush = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; issue_ready = 0;
  endtask

  task automatic check_outputs(input string tag, input logic e_iv, input logic [6:0] e_op,
                               input logic [31:0] e_d1, input logic [31:0] e_d2, input int e_cnt);
    chk({tag, " count"}, 64'(entry_count), 64'(e_cnt));
    chk({tag, " full"},  64'(queue_full),  64'(e_cnt == 4));
    chk({tag, " empty"}, 64'(queue_empty), 64'(e_cnt == 0));
    chk({tag, " issue_valid"}, 64'(issue_valid), 64'(e_iv));
    if (e_iv) begin
      chk({tag, " opcode"}, 64'(issue_data.opcode), 64'(e_op));
      chk({tag, " rs1_data"}, 64'(issue_data.common_data.rs1_data), 64'(e_d1));
      chk({tag, " rs2_data"}, 64'(issue_data.common_data.rs2_data), 64'(e_d2));
    end else begin
      chk({tag, " issue_data_zero"}, 64'(issue_data == '0), 64'(1));
    end
  endtask

  initial begin
    // Ready entry, lone dispatch
    rdy_disp(7'h01, 32'h10, 32'h20, 1, 0,   0, 0, 0, 0, 0);
    idle(0, 0, 0, 1,                         1, 7'h01, 32'h10, 32'h20, 1);
    idle(0, 0, 0, 1,                         0, 0, 0, 0, 0);
    // CDB wakeup: one-cycle latency
    add(1, 7'h02, 6'h05, 0, 0, 6'h00, 1, 32'h22, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
    idle(1, 6'h05, 32'hDEADBEEF, 1,          0, 0, 0, 0, 1);
    idle(0, 0, 0, 1,                         1, 7'h02, 32'hDEADBEEF, 32'h22, 1);
    // Out-of-order issue
    add(1, 7'h03, 6'h03, 0, 0, 6'h00, 1, 32'h33, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    rdy_disp(7'h04, 32'h41, 32'h42, 0, 0,   0, 0, 0, 0, 1);
    idle(0, 0, 0, 1,                         1, 7'h04, 32'h41, 32'h42, 2);
    idle(1, 6'h03, 32'h3030, 1,              0, 0, 0, 0, 1);
    idle(0, 0, 0, 1,                         1, 7'h03, 32'h3030, 32'h33, 1);
    // Full / stall
    rdy_disp(7'h05, 32'h50, 32'h51, 0, 0,   0, 0, 0, 0, 0);
    rdy_disp(7'h06, 32'h60, 32'h61, 0, 0,   1, 7'h05, 32'h50, 32'h51, 1);
    rdy_disp(7'h07, 32'h70, 32'h71, 0, 0,   1, 7'h05, 32'h50, 32'h51, 2);
    rdy_disp(7'h08, 32'h80, 32'h81, 0, 0,   1, 7'h05, 32'h50, 32'h51, 3);
    rdy_disp(7'h09, 32'h90, 32'h91, 0, 0,   1, 7'h05, 32'h50, 32'h51, 4);  // dropped
    rdy_disp(7'h0A, 32'hA0, 32'hA1, 1, 0,   1, 7'h05, 32'h50, 32'h51, 4);  // dropped despite issue
    rdy_disp(7'h0B, 32'hB0, 32'hB1, 0, 0,   1, 7'h06, 32'h60, 32'h61, 3);  // lands at index 3
    idle(0, 0, 0, 1,                         1, 7'h06, 32'h60, 32'h61, 4);
    idle(0, 0, 0, 1,                         1, 7'h07, 32'h70, 32'h71, 3);
    idle(0, 0, 0, 1,                         1, 7'h08, 32'h80, 32'h81, 2);
    idle(0, 0, 0, 1,                         1, 7'h0B, 32'hB0, 32'hB1, 1);
    // Simultaneous issue + dispatch
    rdy_disp(7'h0C, 32'hC0, 32'hC1, 0, 0,   0, 0, 0, 0, 0);
    add(1, 7'h0D, 6'h07, 0, 0, 6'h00, 1, 32'hD1, 0, 0, 0, 0, 0,   1, 7'h0C, 32'hC0, 32'hC1, 1);
    rdy_disp(7'h0E, 32'hE0, 32'hE1, 1, 0,   1, 7'h0C, 32'hC0, 32'hC1, 2);
    idle(0, 0, 0, 1,                         1, 7'h0E, 32'hE0, 32'hE1, 2);
    idle(1, 6'h07, 32'h7777, 0,              0, 0, 0, 0, 1);
    idle(0, 0, 0, 1,                         1, 7'h0D, 32'h7777, 32'hD1, 1);
    // Flush with coincident dispatch
    rdy_disp(7'h10, 32'h100, 32'h101, 0, 0, 0, 0, 0, 0, 0);
    rdy_disp(7'h11, 32'h110, 32'h111, 0, 0, 1, 7'h10, 32'h100, 32'h101, 1);
    rdy_disp(7'h12, 32'h120, 32'h121, 0, 0, 1, 7'h10, 32'h100, 32'h101, 2);
    rdy_disp(7'h13, 32'h130, 32'h131, 0, 1, 1, 7'h10, 32'h100, 32'h101, 3);
    idle(0, 0, 0, 1,                         0, 0, 0, 0, 0);
    // Broadcast coinciding with dispatch is captured
    add(1, 7'h14, 6'h09, 0, 0, 6'h00, 1, 32'h42, 1, 6'h09, 32'h9999, 0, 0,   0, 0, 0, 0, 0);
    idle(0, 0, 0, 1,                         1, 7'h14, 32'h9999, 32'h42, 1);
    // Valid source never overwritten
    add(1, 7'h15, 6'h09, 1, 32'h1111, 6'h09, 0, 0, 1, 6'h09, 32'hAAAA, 0, 0,   0, 0, 0, 0, 0);
    idle(1, 6'h09, 32'hBBBB, 0,              1, 7'h15, 32'h1111, 32'hAAAA, 1);
    idle(0, 0, 0, 1,                         1, 7'h15, 32'h1111, 32'hAAAA, 1);
    idle(0, 0, 0, 0,                         0, 0, 0, 0, 0);

    // Reset state
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < nv; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      dispatch_en = vecs[i].den;
      dispatch_data = '0;
      dispatch_data.opcode = vecs[i].op;
      dispatch_data.common_data.rd_tag = vecs[i].op[5:0];
      dispatch_data.common_data.rs1_tag = vecs[i].t1;
      dispatch_data.common_data.rs1_data_valid = vecs[i].v1;
      dispatch_data.common_data.rs1_data = vecs[i].d1;
      dispatch_data.common_data.rs2_tag = vecs[i].t2;
      dispatch_data.common_data.rs2_data_valid = vecs[i].v2;
      dispatch_data.common_data.rs2_data = vecs[i].d2;
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_data = vecs[i].cd;
      issue_ready = vecs[i].ir; flush = vecs[i].fl;
      @(negedge clk);
      check_outputs(tag, vecs[i].e_iv, vecs[i].e_op, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // Reset mid-operation discards entries and the in-progress handshake
    drive_idle();
    dispatch_en = 1;
    dispatch_data.opcode = 7'h20;
    dispatch_data.common_data.rs1_data_valid = 1;
    dispatch_data.common_data.rs2_data_valid = 1;
    @(posedge clk); #1;
    dispatch_data.opcode = 7'h21;
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs("pre_rst", 1, 7'h20, 0, 0, 2);
    rst_n = 0; issue_ready = 1; dispatch_data.opcode = 7'h22;
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1;
    @(negedge clk);
    check_outputs("mid_rst", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer-unit reservation station, directly downstream of the dispatch generator.
- Accepts int_fifo_data entries when int_dispatch_en is asserted and holds up to DEPTH of them.
- Snoops the common data bus (CDB) to capture pending source operands.
- Issues the oldest entry with both operands valid to the integer execution unit over a valid/ready handshake.
- Collapsing storage: index 0 is always the oldest entry.

Parameters:
- DEPTH, 4, number of entries; power of two not required; minimum 2.
- TAG_W, 6, width of rs1_tag, rs2_tag, rd_tag and cdb_tag.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dispatch_en  in  1  write request (int_dispatch_en from dispatch).
- dispatch_data  in  int_fifo_data (struct)  opcode, func3, func7, common_data.
- flush  in  1  branch-mispredict flush; clears the queue.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  producer tag being broadcast.
- cdb_data  in  32  result value being broadcast.
- issue_ready  in  1  integer unit can accept an instruction this cycle.
- issue_valid  out  1  issue_data holds a ready entry.
- issue_data  out  int_fifo_data (struct)  selected entry, operands resolved.
- queue_full  out  1  count == DEPTH; upstream must stall dispatch.
- queue_empty  out  1  count == 0.
- entry_count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rst_n low at a clock edge):
  - all entries invalid; entry_count=0; queue_empty=1; queue_full=0; issue_valid=0; issue_data=0.
  - Reset applied mid-operation discards all entries, including any handshake in progress that cycle.
- Entry ready: valid && rs1_data_valid && rs2_data_valid, using registered entry state.
- Selection (combinational):
  - lowest-index ready entry; issue_valid = any entry ready; issue_data = that entry.
  - No stability guarantee while issue_ready is low: an older entry waking up takes precedence next cycle.
- Issue fires when issue_valid && issue_ready. The issued entry k is removed at the edge; entries k+1..count-1 shift down by one, preserving age order.
- Dispatch is accepted when dispatch_en && !queue_full && !flush.
  - Write index = count, or count-1 if an issue fires in the same cycle.
  - dispatch_en while queue_full is dropped, even if an issue fires that cycle.
- Simultaneous issue and dispatch: entry_count unchanged.
- CDB snoop, every cycle cdb_valid=1:
  - For each valid entry and each source with data_valid=0 and tag == cdb_tag: capture cdb_data into rsX_data and set rsX_data_valid=1 at the edge.
  - The incoming dispatch_data is snooped the same way before being written, so a broadcast coinciding with dispatch is never missed.
  - A source already valid is never overwritten.
  - Snoop applies to shifted entries at their new position.
- Wakeup latency (macro absent):
  - entry woken by CDB in cycle N is issuable in cycle N+1.
  - dispatched entry with both operands valid is issuable the cycle after the write.
- Flush: has priority over dispatch, issue and snoop. At the next edge all entries are invalid and entry_count=0. issue_valid is still combinationally driven in the flush cycle; the integer unit must ignore it when flush=1.
- entry_count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: INT_IQ_CDB_BYPASS_EN
- Defined:
  - an entry whose only missing operand(s) match the current CDB broadcast counts as ready in cycle N.
  - issue_data carries cdb_data forwarded into the matching source field(s), with data_valid=1.
  - Selection still picks the lowest index.
- Not defined: readiness uses registered state only (one-cycle wakeup latency above).

Test Plan:
- Ready entry, lone dispatch: empty queue; dispatch ADD with rs1=0x10, rs2=0x20, both valid; issue_ready=1 -> issue_valid=1 next cycle with data 0x10/0x20, entry_count returns 0 after the handshake.
- CDB wakeup: dispatch entry with rs1_tag=6'h05 invalid; cdb_valid with tag 6'h05, data 0xDEADBEEF in cycle N -> rs1_data=0xDEADBEEF captured; issue_valid=1 in N+1 (in N with INT_IQ_CDB_BYPASS_EN).
- Out-of-order issue: entry0 waits on tag 6'h03, entry1 ready -> entry1 issues first; entry0 stays at index 0, count 2->1; tag 3 broadcast -> entry0 issues.
- Full/stall: four ready entries with issue_ready=0 -> queue_full=1; fifth dispatch_en is dropped, count stays 4; one issue -> queue_full=0 and the next dispatch is accepted at index 3.
- Simultaneous issue+dispatch: count=2, issue index 0 and dispatch in the same cycle -> count stays 2; old entry1 moves to index 0, new entry lands at index 1.
- Flush: three entries plus dispatch_en and flush in the same cycle -> next cycle entry_count=0, queue_empty=1, issue_valid=0; the dispatched entry is absent.
